mac_frame_accumulator: RTL
==========================

Name: mac_frame_accumulator

Overview:
- Downstream consumer of the N x N pipelined multiplier.
- Takes its product/out_valid stream and sums every LEN consecutive valid products into one frame result (dot product).
- Results go into a 2-entry output buffer with a valid/ready handshake. The multiplier has no backpressure, so this block absorbs downstream stalls and flags any frame result it cannot store.

Parameters:
- N, 4, operand width of the upstream multiplier; the product is 2N bits.
- LEN, 8, number of valid products per frame; must be >= 2.
- ACC_W, 2*N+$clog2(LEN), accumulator and result width; the default never overflows.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush of frame state, buffer and error flag; priority over all other inputs.
- in_valid  input  1  product valid; connects to the multiplier out_valid.
- in_product  input  2N  unsigned product; connects to the multiplier product.
- out_valid  output  1  buffer head holds a valid frame result.
- out_ready  input  1  downstream accepts the head this cycle.
- out_sum  output  ACC_W  frame result at the buffer head; 0 when the buffer is empty.
- frame_pos  output  $clog2(LEN)  number of products accumulated in the current frame (0..LEN-1).
- overflow  output  1  sticky: a completed frame was dropped because the buffer was full.

Behaviour:
- Reset (rst_n low, asynchronous):
  - acc=0, frame_pos=0, buffer empty.
  - out_valid=0, out_sum=0, overflow=0.
  - Reset mid-frame discards partial sums; the first valid product after release starts a new frame.
- Accumulate, on each cycle with in_valid=1:
  - If frame_pos==0: acc <= zero-extended in_product. Otherwise acc <= acc + in_product, modulo 2^ACC_W (wraps, no saturation).
  - frame_pos increments; cycles with in_valid=0 leave acc and frame_pos unchanged, so gaps are allowed.
- Frame completion, when in_valid=1 and frame_pos==LEN-1:
  - Result = acc + in_product, pushed into the buffer in the same cycle.
  - frame_pos wraps to 0.
  - Latency: out_valid rises on the clock edge that accepts the last product, i.e. the result is visible the cycle after the last product is presented.
- Output buffer: a 2-entry FIFO with states EMPTY, ONE and FULL.
  - Pop when out_valid && out_ready.
  - Push when a frame completes.
  - Push and pop in the same cycle are both honoured in every state. FULL with push and pop stays FULL with correct order.
  - Push while FULL without a pop: the result is dropped, buffer contents are unchanged, and overflow is set to 1 (sticky).
- Output stability: out_sum and out_valid must not change while out_valid=1 and out_ready=0, except through clear or reset.
- clear=1:
  - Next edge: acc=0, frame_pos=0, buffer EMPTY, overflow=0.
  - Any in_valid and out_ready in the same cycle are ignored.

Decomposition:
- Shared package:
  - ACC_W derivation function (clog2-based).
  - Buffer state encoding constants: EMPTY, ONE, FULL.
- Sub-module: result_fifo2.
  - Generic 2-entry synchronous FIFO, parameterized width.
  - Ports: push, push_data, pop, head_valid, head_data, full.
  - Same clk/rst_n convention.
- The top level holds the accumulator, the frame counter and the overflow flag.

Test Plan:
All tests use N=4, LEN=8, ACC_W=11.
1. Basic frame: products 1..8 on consecutive cycles with out_ready=1 -> out_valid pulses for one cycle with out_sum=36, the cycle after product 8; frame_pos returns to 0.
2. Max values: 8 products of 225 -> out_sum=1800, no wrap. Then 8 products of 0 -> out_sum=0 (the new frame does not inherit acc).
3. Gapped input: products 5 on every other cycle, 8 valid total -> out_sum=40; invalid cycles leave frame_pos unchanged.
4. Backpressure and drop: out_ready=0, three frames with sums 8, 16 and 24 -> buffer holds 8 and 16, overflow=1 after the third frame. Then out_ready=1 -> 8 then 16 delivered in order, buffer empty.
5. Simultaneous push/pop while FULL: complete a frame on the same cycle as out_ready=1 -> no drop, overflow stays 0, order preserved.
6. Reset and clear: rst_n low after 3 products -> all outputs 0 immediately; the next 8 products of 2 give out_sum=16. Repeat with clear after 5 products -> same result, overflow cleared.

Source files
------------

// File: rtl/mac_frame_accumulator_pkg.sv
// mac_frame_accumulator_pkg: shared width helper and result buffer state encoding
package mac_frame_accumulator_pkg;
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;
    // Wide enough that LEN full-scale 2N-bit products never wrap
    function automatic int acc_width(input int n, input int len);
        return 2 * n + $clog2(len);
    endfunction
endpackage

// File: rtl/mac_frame_accumulator_if.sv
// mac_frame_accumulator_if: product stream in, frame results out with valid/ready
interface mac_frame_accumulator_if import mac_frame_accumulator_pkg::*; #(
    parameter int N     = 4,
    parameter int ACC_W = acc_width(4, 8)
);
    logic             in_valid;
    logic [2*N-1:0]   in_product;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    modport master (output in_valid, in_product, out_ready, input out_valid, out_sum);
    modport slave (input in_valid, in_product, out_ready, output out_valid, out_sum);
endinterface

// File: rtl/mac_frame_accumulator_result_fifo2.sv
// result_fifo2: 2-entry synchronous FIFO, push and pop honoured together in every state
module result_fifo2 import mac_frame_accumulator_pkg::*; #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    output logic         full
);
    logic [1:0]   state, state_nx;
    logic [W-1:0] mem0, mem1, mem0_nx, mem1_nx;
    logic         pop_ok;
    assign head_valid = state != EMPTY;
    assign full       = state == FULL;
    assign head_data  = head_valid ? mem0 : '0;
    assign pop_ok     = pop && head_valid;
    // mem0 is always the head; a push into a full buffer without a pop is dropped
    always_comb begin
        state_nx = state;
        mem0_nx  = mem0;
        mem1_nx  = mem1;
        case (state)
            EMPTY: begin
                mem0_nx  = push ? push_data : mem0;
                state_nx = push ? ONE : EMPTY;
            end
            ONE: begin
                mem0_nx  = (push && pop_ok) ? push_data : mem0;
                mem1_nx  = (push && !pop_ok) ? push_data : mem1;
                state_nx = (push && !pop_ok) ? FULL : (pop_ok && !push) ? EMPTY : ONE;
            end
            FULL: begin
                mem0_nx  = pop_ok ? mem1 : mem0;
                mem1_nx  = (pop_ok && push) ? push_data : mem1;
                state_nx = (pop_ok && !push) ? ONE : FULL;
            end
            default: state_nx = EMPTY;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            mem0  <= '0;
            mem1  <= '0;
        end else if (clear) begin
            state <= EMPTY;
            mem0  <= '0;
            mem1  <= '0;
        end else begin
            state <= state_nx;
            mem0  <= mem0_nx;
            mem1  <= mem1_nx;
        end
    end
endmodule

// File: rtl/mac_frame_accumulator.sv
// mac_frame_accumulator: sums every LEN valid products into a buffered frame result
module mac_frame_accumulator import mac_frame_accumulator_pkg::*; #(
    parameter int N     = 4,
    parameter int LEN   = 8,
    parameter int ACC_W = acc_width(N, LEN),
    localparam int PW   = $clog2(LEN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    mac_frame_accumulator_if.slave  bus,
    output logic [PW-1:0]           frame_pos,
    output logic                    overflow
);
    localparam logic [PW-1:0] LAST = PW'(LEN - 1);
    logic [ACC_W-1:0] acc, sum;
    logic             done, push, pop, full;
    // The first product of a frame replaces acc, so no separate clear of acc is needed
    assign sum  = (frame_pos == '0 ? '0 : acc) + ACC_W'(bus.in_product);
    assign done = bus.in_valid && frame_pos == LAST;
    assign push = done && !clear;
    assign pop  = bus.out_valid && bus.out_ready && !clear;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            frame_pos <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            frame_pos <= '0;
            overflow  <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                acc       <= sum;
                frame_pos <= done ? '0 : frame_pos + PW'(1);
            end
            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end
    result_fifo2 #(.W(ACC_W)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .push       (push),
        .push_data  (sum),
        .pop        (pop),
        .head_valid (bus.out_valid),
        .head_data  (bus.out_sum),
        .full       (full)
    );
endmodule
